mac_rx_ctrl: RTL and testbench
==============================

MAC_RX_CTRL -- requirements
Module: mac_rx_ctrl

Interface
REQ-001 SHALL have parameter MIN_LEN, default 60: smallest accepted frame in bytes after CRC strip; shorter frames are runts.
REQ-002 SHALL have parameter CNT_W, default 16: width of each statistics counter.
REQ-003 SHALL have one clock and an asynchronous, active-high reset; ports clk and rst.
REQ-004 clk  input  1  system clock, 50 MHz, shared with the RMII receive interface.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 doorbell  input  1  one-cycle pulse from the RX interface: good frame present in pktbuf.
REQ-007 pktbuf_maxaddr  input  11  index of the last payload byte; valid while doorbell is high.
REQ-008 crs_dv  input  1  raw RMII carrier/data-valid, i.e. the RX interface's rx_axi_valid.
REQ-009 rd_data  input  8  pktbuf byte at rd_addr, combinational.
REQ-010 rd_addr  output  11  pktbuf read index.
REQ-011 mac_rx_en  output  1  RX interface may accept a frame; while low, the interface is held off.
REQ-012 m_tdata / m_tvalid / m_tlast  output  8/1/1  AXI-stream byte output.
REQ-013 m_tready  input  1  AXI-stream back-pressure.
REQ-014 frame_cnt / runt_cnt / drop_cnt  output  CNT_W each  frames streamed, runts discarded, frames lost while held off.

Function
REQ-015 SHALL implement the states IDLE, CHECK, STREAM and REARM.
REQ-016 IDLE: mac_rx_en=1 and m_tvalid=0. On doorbell, latch len=pktbuf_maxaddr, clear idx, and go to CHECK; mac_rx_en=0 from the next cycle.
REQ-017 CHECK (one cycle): if len+1 < MIN_LEN, increment runt_cnt and go to REARM; otherwise go to STREAM.
REQ-018 STREAM: rd_addr=idx, m_tdata=rd_data, m_tvalid=1, and m_tlast=(idx==len).
REQ-019 STREAM: idx advances only on a cycle with m_tvalid and m_tready both high; m_tdata and m_tlast stay stable while m_tready=0.
REQ-020 On the handshake with m_tlast=1, SHALL increment frame_cnt and go to REARM.
REQ-021 REARM: mac_rx_en stays 0 until a cycle with crs_dv=0; then mac_rx_en=1 and the state becomes IDLE on the next cycle, so the RX interface is never enabled mid-frame.
REQ-022 A rising edge of crs_dv while mac_rx_en=0, in any state, SHALL increment drop_cnt once per edge.
REQ-023 All counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-024 Doorbell outside IDLE SHALL be ignored; it cannot occur while the controller holds the RX interface off.
REQ-025 Latency: the first byte is valid 2 cycles after the doorbell cycle (doorbell, CHECK, then STREAM).
REQ-026 len=1513, the maximum, SHALL stream 1514 bytes; no index overflow is possible in 11 bits.
REQ-027 rd_addr SHALL hold its last value outside STREAM.

Reset
REQ-028 Reset SHALL force state=IDLE, mac_rx_en=1, m_tvalid=0, m_tlast=0, rd_addr=0, len=0, idx=0 and all counters to 0.
REQ-029 Reset asserted mid-STREAM SHALL drop m_tvalid immediately (asynchronously); the partial frame is abandoned and not counted.
REQ-030 The crs_dv edge detector register SHALL reset to 0.

Structure
REQ-031 Package mac_pkg SHALL hold the state enum, PKTBUF_AW=11, PKTBUF_BYTES=1518 and the default MIN_LEN.
REQ-032 One sub-module, sat_counter, SHALL provide a parameterised-width saturating counter with an increment pulse; it is instantiated three times.

Verification
REQ-033 Doorbell with maxaddr=63 and tready held at 1 -> 64 bytes on consecutive cycles from doorbell+2, tlast on byte 64, frame_cnt=1, mac_rx_en back to 1 once crs_dv=0.
REQ-034 Doorbell with maxaddr=40 -> no tvalid, runt_cnt=1, frame_cnt=0, mac_rx_en=0 for at least 2 cycles.
REQ-035 maxaddr=99 with tready toggling 1,0,1,0 -> exactly 100 handshakes, data in order 0..99, tdata held stable on every stalled cycle.
REQ-036 crs_dv pulsed high twice during STREAM and held high at the end of REARM -> drop_cnt=2; mac_rx_en rises only on the first cycle after crs_dv falls.
REQ-037 Reset asserted at byte 10 of a 200-byte frame -> tvalid=0 at once, counters 0, IDLE, a fresh frame then streams correctly.
REQ-038 drop_cnt preloaded, or CNT_W=4, with 20 drop edges -> count reads 15 and holds.

Source files
------------

// File: rtl/mac_pkg.sv
// mac_pkg: shared types and constants for the MAC receive controller
package mac_pkg;
  localparam int PKTBUF_AW = 11;
  localparam int PKTBUF_BYTES = 1518;
  localparam int MIN_LEN_DEF = 60;
  typedef enum logic [1:0] {IDLE, CHECK, STREAM, REARM} rx_state_e;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: counter that increments on a pulse and sticks at all-ones
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = (inc && !(&cnt_q)) ? cnt_q + W'(1) : cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt = cnt_q;
endmodule

// File: rtl/mac_rx_ctrl.sv
// mac_rx_ctrl: streams frames from the packet buffer, gates the RX interface and keeps statistics
module mac_rx_ctrl import mac_pkg::*; #(
  parameter int MIN_LEN = MIN_LEN_DEF,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 doorbell,
  input  logic [PKTBUF_AW-1:0] pktbuf_maxaddr,
  input  logic                 crs_dv,
  input  logic [7:0]           rd_data,
  output logic [PKTBUF_AW-1:0] rd_addr,
  output logic                 mac_rx_en,
  output logic [7:0]           m_tdata,
  output logic                 m_tvalid,
  output logic                 m_tlast,
  input  logic                 m_tready,
  output logic [CNT_W-1:0]     frame_cnt,
  output logic [CNT_W-1:0]     runt_cnt,
  output logic [CNT_W-1:0]     drop_cnt
);
  rx_state_e state_q, state_d;
  logic [PKTBUF_AW-1:0] len_q, len_d, idx_q, idx_d, rd_addr_q;
  logic crs_q, runt, runt_inc, frame_inc, drop_inc;
  assign runt = 32'(len_q) + 32'd1 < 32'(MIN_LEN);
  assign mac_rx_en = state_q == IDLE;
  assign m_tvalid = state_q == STREAM;
  assign m_tlast = m_tvalid && idx_q == len_q;
  assign m_tdata = rd_data;
  assign rd_addr = m_tvalid ? idx_q : rd_addr_q;
  assign drop_inc = crs_dv && !crs_q && !mac_rx_en;
  always_comb begin
    state_d = state_q;
    len_d = len_q;
    idx_d = idx_q;
    runt_inc = 1'b0;
    frame_inc = 1'b0;
    case (state_q)
      IDLE: if (doorbell) begin
        len_d = pktbuf_maxaddr;
        idx_d = '0;
        state_d = CHECK;
      end
      CHECK: begin
        runt_inc = runt;
        state_d = runt ? REARM : STREAM;
      end
      STREAM: if (m_tready) begin
        frame_inc = m_tlast;
        state_d = m_tlast ? REARM : STREAM;
        idx_d = m_tlast ? idx_q : idx_q + 11'd1;
      end
      REARM: state_d = crs_dv ? REARM : IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      len_q <= '0;
      idx_q <= '0;
      rd_addr_q <= '0;
      crs_q <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q <= len_d;
      idx_q <= idx_d;
      rd_addr_q <= rd_addr;
      crs_q <= crs_dv;
    end
  sat_counter #(.W(CNT_W)) u_frame_cnt (.clk(clk), .rst(rst), .inc(frame_inc), .cnt(frame_cnt));
  sat_counter #(.W(CNT_W)) u_runt_cnt (.clk(clk), .rst(rst), .inc(runt_inc), .cnt(runt_cnt));
  sat_counter #(.W(CNT_W)) u_drop_cnt (.clk(clk), .rst(rst), .inc(drop_inc), .cnt(drop_cnt));
endmodule

// File: tb/tb_mac_rx_ctrl.sv
// tb_mac_rx_ctrl: randomized self-checking bench for mac_rx_ctrl against a frame-level model
module tb_mac_rx_ctrl;
  localparam int MIN_LEN = 60;
  logic clk = 1'b0;
  logic rst, doorbell, crs_dv, m_tready;
  logic [10:0] pktbuf_maxaddr, rd_addr, rd_addr4;
  logic [7:0] rd_data, rd_data4, m_tdata, m_tdata4;
  logic mac_rx_en, m_tvalid, m_tlast, mac_rx_en4, m_tvalid4, m_tlast4;
  logic [15:0] frame_cnt, runt_cnt, drop_cnt;
  logic [3:0] frame_cnt4, runt_cnt4, drop_cnt4;
  logic [7:0] mem [0:2047];
  int checks = 0;
  int errors = 0;
  int frames_exp = 0;
  int runts_exp = 0;
  int drops_exp = 0;
  always #5 clk = ~clk;
  assign rd_data = mem[rd_addr];
  assign rd_data4 = mem[rd_addr4];
  mac_rx_ctrl #(.MIN_LEN(MIN_LEN), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .doorbell(doorbell), .pktbuf_maxaddr(pktbuf_maxaddr), .crs_dv(crs_dv),
    .rd_data(rd_data), .rd_addr(rd_addr), .mac_rx_en(mac_rx_en), .m_tdata(m_tdata),
    .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
    .frame_cnt(frame_cnt), .runt_cnt(runt_cnt), .drop_cnt(drop_cnt)
  );
  mac_rx_ctrl #(.MIN_LEN(MIN_LEN), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .doorbell(doorbell), .pktbuf_maxaddr(pktbuf_maxaddr), .crs_dv(crs_dv),
    .rd_data(rd_data4), .rd_addr(rd_addr4), .mac_rx_en(mac_rx_en4), .m_tdata(m_tdata4),
    .m_tvalid(m_tvalid4), .m_tlast(m_tlast4), .m_tready(m_tready),
    .frame_cnt(frame_cnt4), .runt_cnt(runt_cnt4), .drop_cnt(drop_cnt4)
  );
  function automatic int sat(input int n, input int m);
    return n > m ? m : n;
  endfunction
  task automatic fill_mem(input bit ramp);
    for (int i = 0; i < 2048; i++) mem[i] = ramp ? 8'(i) : 8'($urandom);
  endtask
  task automatic run_frame(input int len, input int mode, input bit crs, input int abort);
    logic [7:0] exp [$];
    int got = 0;
    int cyc = 0;
    logic stalled = 1'b0;
    logic [7:0] held_d = '0;
    logic held_l = 1'b0;
    bit is_runt = len + 1 < MIN_LEN;
    for (int i = 0; i <= len; i++) exp.push_back(mem[i]);
    doorbell = 1'b1;
    pktbuf_maxaddr = 11'(len);
    @(posedge clk); #1;
    doorbell = 1'b0;
    pktbuf_maxaddr = 11'($urandom);
    checks++;
    if (m_tvalid !== 1'b0 || mac_rx_en !== 1'b0) begin
      errors++;
      $display("FAIL check_cycle len=%0d tvalid=%b en=%b expected 0 0", len, m_tvalid, mac_rx_en);
    end
    @(posedge clk); #1;
    if (is_runt) begin
      runts_exp++;
      checks++;
      if (m_tvalid !== 1'b0 || mac_rx_en !== 1'b0 || runt_cnt !== 16'(sat(runts_exp, 65535)) || runt_cnt4 !== 4'(sat(runts_exp, 15)) || frame_cnt !== 16'(frames_exp)) begin
        errors++;
        $display("FAIL runt len=%0d tvalid=%b en=%b runt_cnt=%0d frame_cnt=%0d expected 0 0 %0d %0d", len, m_tvalid, mac_rx_en, runt_cnt, frame_cnt, runts_exp, frames_exp);
      end
      @(posedge clk); #1;
      checks++;
      if (mac_rx_en !== 1'b1 || m_tvalid !== 1'b0) begin
        errors++;
        $display("FAIL runt_rearm en=%b tvalid=%b expected 1 0", mac_rx_en, m_tvalid);
      end
      return;
    end
    checks++;
    if (m_tvalid !== 1'b1) begin
      errors++;
      $display("FAIL latency tvalid=%b at doorbell+2 expected 1", m_tvalid);
    end
    while (got <= len && cyc < 8000) begin
      m_tready = mode == 0 ? 1'b1 : mode == 1 ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
      crs_dv = crs && ((cyc >= 3 && cyc < 5) || cyc >= 7);
      doorbell = mode == 2 && $urandom_range(0, 7) == 0;
      pktbuf_maxaddr = 11'($urandom);
      if (stalled) begin
        checks++;
        if (m_tdata !== held_d || m_tlast !== held_l) begin
          errors++;
          $display("FAIL stall_stable byte=%0d data=%h last=%b expected %h %b", got, m_tdata, m_tlast, held_d, held_l);
        end
      end
      checks++;
      if (m_tvalid !== 1'b1 || mac_rx_en !== 1'b0) begin
        errors++;
        $display("FAIL stream_state byte=%0d tvalid=%b en=%b expected 1 0", got, m_tvalid, mac_rx_en);
      end
      if (m_tready) begin
        checks++;
        if (m_tdata !== exp[got] || m_tlast !== (got == len)) begin
          errors++;
          $display("FAIL data byte=%0d data=%h last=%b expected %h %b", got, m_tdata, m_tlast, exp[got], got == len);
        end
        got++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        held_d = m_tdata;
        held_l = m_tlast;
      end
      if (abort > 0 && got == abort) begin
        rst = 1'b1;
        #1;
        frames_exp = 0;
        runts_exp = 0;
        drops_exp = 0;
        checks++;
        if (m_tvalid !== 1'b0 || m_tlast !== 1'b0 || mac_rx_en !== 1'b1 || rd_addr !== 11'd0 || frame_cnt !== 16'd0 || runt_cnt !== 16'd0 || drop_cnt !== 16'd0) begin
          errors++;
          $display("FAIL reset_mid tvalid=%b last=%b en=%b addr=%0d cnts=%0d/%0d/%0d expected 0 0 1 0 0/0/0", m_tvalid, m_tlast, mac_rx_en, rd_addr, frame_cnt, runt_cnt, drop_cnt);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        m_tready = 1'b1;
        doorbell = 1'b0;
        crs_dv = 1'b0;
        return;
      end
      @(posedge clk); #1;
      cyc++;
    end
    doorbell = 1'b0;
    frames_exp++;
    checks++;
    if (got != len + 1 || (mode == 0 && cyc != len + 1)) begin
      errors++;
      $display("FAIL handshake_count got=%0d cycles=%0d expected %0d", got, cyc, len + 1);
    end
    checks++;
    if (m_tvalid !== 1'b0 || mac_rx_en !== 1'b0 || frame_cnt !== 16'(sat(frames_exp, 65535)) || frame_cnt4 !== 4'(sat(frames_exp, 15))) begin
      errors++;
      $display("FAIL frame_done tvalid=%b en=%b frame_cnt=%0d frame_cnt4=%0d expected 0 0 %0d %0d", m_tvalid, mac_rx_en, frame_cnt, frame_cnt4, frames_exp, sat(frames_exp, 15));
    end
    if (crs) begin
      drops_exp += 2;
      repeat (3) begin
        @(posedge clk); #1;
        checks++;
        if (mac_rx_en !== 1'b0) begin
          errors++;
          $display("FAIL rearm_hold en=%b expected 0", mac_rx_en);
        end
      end
      crs_dv = 1'b0;
    end
    checks++;
    if (mac_rx_en !== 1'b0 || drop_cnt !== 16'(sat(drops_exp, 65535)) || drop_cnt4 !== 4'(sat(drops_exp, 15))) begin
      errors++;
      $display("FAIL drop_count en=%b drop_cnt=%0d drop_cnt4=%0d expected 0 %0d %0d", mac_rx_en, drop_cnt, drop_cnt4, drops_exp, sat(drops_exp, 15));
    end
    @(posedge clk); #1;
    checks++;
    if (mac_rx_en !== 1'b1 || m_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL rearm_release en=%b tvalid=%b expected 1 0", mac_rx_en, m_tvalid);
    end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    doorbell = 1'b0;
    crs_dv = 1'b0;
    m_tready = 1'b1;
    pktbuf_maxaddr = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (mac_rx_en !== 1'b1 || m_tvalid !== 1'b0 || m_tlast !== 1'b0 || rd_addr !== 11'd0 || frame_cnt !== 16'd0 || runt_cnt !== 16'd0 || drop_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset en=%b tvalid=%b last=%b addr=%0d cnts=%0d/%0d/%0d expected 1 0 0 0 0/0/0", mac_rx_en, m_tvalid, m_tlast, rd_addr, frame_cnt, runt_cnt, drop_cnt);
    end
    rst = 1'b0;
    crs_dv = 1'b1;
    @(posedge clk); #1;
    crs_dv = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (mac_rx_en !== 1'b1 || m_tvalid !== 1'b0 || drop_cnt !== 16'd0) begin
      errors++;
      $display("FAIL idle_edge en=%b tvalid=%b drop_cnt=%0d expected 1 0 0", mac_rx_en, m_tvalid, drop_cnt);
    end
  endtask
  task automatic test_stream();
    fill_mem(1'b0);
    run_frame(63, 0, 1'b0, 0);
  endtask
  task automatic test_runt();
    run_frame(40, 0, 1'b0, 0);
    run_frame(58, 0, 1'b0, 0);
    run_frame(59, 0, 1'b0, 0);
  endtask
  task automatic test_backpressure();
    fill_mem(1'b1);
    run_frame(99, 1, 1'b0, 0);
  endtask
  task automatic test_drop();
    fill_mem(1'b0);
    run_frame(63, 0, 1'b1, 0);
  endtask
  task automatic test_saturate();
    doorbell = 1'b1;
    pktbuf_maxaddr = 11'd63;
    m_tready = 1'b0;
    @(posedge clk); #1;
    doorbell = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 20; i++) begin
      crs_dv = 1'b1;
      @(posedge clk); #1;
      crs_dv = 1'b0;
      @(posedge clk); #1;
      drops_exp++;
      if (i == 5 || i == 12 || i == 19) begin
        checks++;
        if (drop_cnt4 !== 4'(sat(drops_exp, 15)) || drop_cnt !== 16'(drops_exp)) begin
          errors++;
          $display("FAIL saturate edges=%0d drop_cnt4=%0d drop_cnt=%0d expected %0d %0d", i + 1, drop_cnt4, drop_cnt, sat(drops_exp, 15), drops_exp);
        end
      end
    end
    m_tready = 1'b1;
    repeat (64) @(posedge clk);
    #1;
    frames_exp++;
    checks++;
    if (m_tvalid !== 1'b0 || frame_cnt !== 16'(frames_exp)) begin
      errors++;
      $display("FAIL stalled_frame tvalid=%b frame_cnt=%0d expected 0 %0d", m_tvalid, frame_cnt, frames_exp);
    end
    @(posedge clk); #1;
  endtask
  task automatic test_random();
    for (int f = 0; f < 8; f++) begin
      fill_mem(1'b0);
      run_frame($urandom_range(20, 150), 2, 1'b0, 0);
    end
  endtask
  task automatic test_max_len();
    fill_mem(1'b0);
    run_frame(1513, 0, 1'b0, 0);
  endtask
  task automatic test_reset_mid();
    fill_mem(1'b0);
    run_frame(199, 0, 1'b0, 10);
    fill_mem(1'b0);
    run_frame(199, 2, 1'b0, 0);
  endtask
  initial begin
    test_reset();
    test_stream();
    test_runt();
    test_backpressure();
    test_drop();
    test_saturate();
    test_random();
    test_max_len();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
